// File: rtl/register_file.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port.
// Optional macro RF_ZERO_REG_EN hardwires register 0 to zero (reads return 0, writes ignored).
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite,
    input  logic [4:0]  Rs_Addr,
    input  logic [4:0]  Rt_Addr,
    input  logic [4:0]  Rd_Addr,
    input  logic [31:0] Rd_Data,
    output logic [31:0] Rs_Data,
    output logic [31:0] Rt_Data
);

    // Plain array so benches can reach RF.R[i] directly.
    logic [31:0] R [0:31];

    logic wr_en;

`ifdef RF_ZERO_REG_EN
    assign wr_en = RegWrite && (Rd_Addr != 5'd0);
`else
    assign wr_en = RegWrite;
`endif

    // Reset dominates: a write presented while rst is high is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                R[i] <= 32'h0;
            end
        end else if (wr_en) begin
            R[Rd_Addr] <= Rd_Data;
        end
    end

    // No write-to-read bypass: reads see the stored value until the edge.
    always_comb begin
        Rs_Data = R[Rs_Addr];
        Rt_Data = R[Rt_Addr];
`ifdef RF_ZERO_REG_EN
        if (Rs_Addr == 5'd0) Rs_Data = 32'h0;
        if (Rt_Addr == 5'd0) Rt_Data = 32'h0;
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed cases plus randomized traffic
// compared against an array model of the register contents.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        RegWrite;
    logic [4:0]  Rs_Addr;
    logic [4:0]  Rt_Addr;
    logic [4:0]  Rd_Addr;
    logic [31:0] Rd_Data;
    logic [31:0] Rs_Data;
    logic [31:0] Rt_Data;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [0:31];
    logic [31:0] exp_q [$];

    register_file RF (
        .clk      (clk),
        .rst      (rst),
        .RegWrite (RegWrite),
        .Rs_Addr  (Rs_Addr),
        .Rt_Addr  (Rt_Addr),
        .Rd_Addr  (Rd_Addr),
        .Rd_Data  (Rd_Data),
        .Rs_Data  (Rs_Data),
        .Rt_Data  (Rt_Data)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_read(input logic [4:0] a);
`ifdef RF_ZERO_REG_EN
        if (a == 5'd0) return 32'h0;
`endif
        return model[a];
    endfunction

    function automatic void ref_write(input logic [4:0] a, input logic [31:0] d);
`ifdef RF_ZERO_REG_EN
        if (a == 5'd0) return;
`endif
        model[a] = d;
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endfunction

    // scoreboard: pop the oldest expectation and compare
    task automatic compare(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: no expected value queued (observed %h)", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic check_ports(input string tag);
        exp_q.push_back(ref_read(Rs_Addr));
        exp_q.push_back(ref_read(Rt_Addr));
        compare({tag, "_rs"}, Rs_Data);
        compare({tag, "_rt"}, Rt_Data);
    endtask

    task automatic check_const(input string tag, input logic [31:0] obs, input logic [31:0] e);
        exp_q.push_back(e);
        compare(tag, obs);
    endtask

    // driver: present a write at the falling edge, commit at the rising edge
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        RegWrite = 1'b1;
        Rd_Addr  = a;
        Rd_Data  = d;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        ref_write(a, d);
    endtask

    task automatic read_ports(input logic [4:0] a, input logic [4:0] b);
        Rs_Addr = a;
        Rt_Addr = b;
        #1;
    endtask

    initial begin
        RegWrite = 1'b0;
        Rs_Addr  = 5'd0;
        Rt_Addr  = 5'd0;
        Rd_Addr  = 5'd0;
        Rd_Data  = 32'h0;
        rst      = 1'b1;
        ref_clear();
        repeat (2) @(posedge clk);
        #1;

        // reset state
        for (int i = 0; i < 32; i += 4) begin
            read_ports(i[4:0], 5'(31 - i));
            check_ports("reset_state");
        end

        @(negedge clk);
        rst = 1'b0;

        // load every register with random data and read each back
        for (int i = 0; i < 32; i++) write_reg(i[4:0], $urandom);
        write_reg(5'd0, 32'h0000_0000);
        write_reg(5'd1, 32'h1111_1111);
        write_reg(5'd3, 32'h3333_3333);
        for (int i = 0; i < 32; i++) begin
            read_ports(i[4:0], 5'($urandom_range(0, 31)));
            check_ports("load_read");
        end

        read_ports(5'd0, 5'd1);
        check_const("preload_r1", Rt_Data, 32'h1111_1111);
        check_ports("preload_pair");

        // basic write
        write_reg(5'd2, 32'hFFFF_FFFF);
        read_ports(5'd2, 5'd2);
        check_const("basic_write", Rs_Data, 32'hFFFF_FFFF);

        // write disabled for several edges
        @(negedge clk);
        RegWrite = 1'b0;
        Rd_Addr  = 5'd3;
        Rd_Data  = 32'h8787_8787;
        repeat (3) @(posedge clk);
        #1;
        read_ports(5'd3, 5'd3);
        check_const("write_disabled", Rs_Data, 32'h3333_3333);

        // no bypass: old value before the edge, new value after
        @(negedge clk);
        Rs_Addr  = 5'd5;
        Rt_Addr  = 5'd5;
        RegWrite = 1'b1;
        Rd_Addr  = 5'd5;
        Rd_Data  = 32'hA5A5_A5A5;
        #1;
        check_ports("no_bypass_before");
        check_const("same_addr_before", Rt_Data, ref_read(5'd5));
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        ref_write(5'd5, 32'hA5A5_A5A5);
        check_const("no_bypass_after", Rs_Data, 32'hA5A5_A5A5);
        check_const("same_addr_after", Rt_Data, 32'hA5A5_A5A5);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            RegWrite = 1'($urandom_range(0, 1));
            Rd_Addr  = 5'($urandom_range(0, 31));
            Rd_Data  = $urandom;
            Rs_Addr  = ($urandom_range(0, 3) == 0) ? Rd_Addr : 5'($urandom_range(0, 31));
            Rt_Addr  = 5'($urandom_range(0, 31));
            #1;
            check_ports("rand_pre");
            @(posedge clk);
            if (RegWrite) ref_write(Rd_Addr, Rd_Data);
            #1;
            check_ports("rand_post");
        end
        RegWrite = 1'b0;

        // asynchronous reset between edges, with a write pending
        @(negedge clk);
        Rs_Addr  = 5'd2;
        Rt_Addr  = 5'd5;
        RegWrite = 1'b1;
        Rd_Addr  = 5'd7;
        Rd_Data  = 32'hDEAD_BEEF;
        #2;
        rst = 1'b1;
        ref_clear();
        #1;
        check_const("async_rst_rs", Rs_Data, 32'h0);
        check_const("async_rst_rt", Rt_Data, 32'h0);
        @(posedge clk);
        #1;
        read_ports(5'd7, 5'd7);
        check_const("rst_blocks_write", Rs_Data, 32'h0);
        for (int i = 0; i < 32; i++) begin
            read_ports(i[4:0], 5'(31 - i));
            check_ports("rst_all_zero");
        end
        RegWrite = 1'b0;

        // first write after reset release
        @(negedge clk);
        rst = 1'b0;
        write_reg(5'd7, 32'h0BAD_F00D);
        read_ports(5'd7, 5'd6);
        check_const("write_after_rst", Rs_Data, 32'h0BAD_F00D);
        check_ports("after_rst_pair");

        // register 0 behaviour (ordinary by default, hardwired zero with the macro)
        write_reg(5'd0, 32'h1234_5678);
        read_ports(5'd0, 5'd0);
        check_ports("reg0_write");
`ifdef RF_ZERO_REG_EN
        check_const("reg0_zero", Rs_Data, 32'h0);
`else
        check_const("reg0_plain", Rs_Data, 32'h1234_5678);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
